// File: rtl/pipe_reg_pkg.sv
// rtl/pipe_reg_pkg.sv - shared sizing helpers for the pipe_reg valid/ready pipeline
package pipe_reg_pkg;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one valid/data register stage with load enable and INIT reset
module pipe_reg_stage #(
  parameter int              W    = 1,
  parameter logic [W-1:0]    INIT = '0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic         vld_next,
  input  logic [W-1:0] dat_in,
  output logic         vld,
  output logic [W-1:0] dat
);

  logic         vld_d, vld_q;
  logic [W-1:0] dat_d, dat_q;

  // Data only changes on an actual transfer in; it lingers after the word leaves.
  always_comb begin
    vld_d = vld_next;
    dat_d = load ? dat_in : dat_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q <= 1'b0;
      dat_q <= INIT;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld = vld_q;
  assign dat = dat_q;

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - DEPTH-stage valid/ready register pipeline with bubble collapse and flush
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int           W     = 1,
  parameter int           DEPTH = 2,
  parameter logic [W-1:0] INIT  = '0,
  localparam int          CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          in_vld,
  input  logic [W-1:0]  in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [W-1:0]  out_dat,
  input  logic          out_rdy,
  input  logic          flush,
  output logic [CW-1:0] cnt
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] xfer;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH:0]   rdy;
  logic [W-1:0]     dat [DEPTH];
  logic             push, pop;
  logic [CW-1:0]    cnt_d, cnt_q;

  // Ready ripples combinationally from the output back to the input, so an
  // empty stage anywhere lets everything upstream of it advance.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_rdy;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~vld[i] | rdy[i+1];
    end

    in_rdy  = rdy[0] & ~flush;
    xfer    = '0;
    xfer[0] = in_vld & in_rdy;
    for (int i = 1; i < DEPTH; i++) begin
      xfer[i] = vld[i-1] & rdy[i];
    end

    vld_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_d[i] = ~flush & (xfer[i] | (vld[i] & ~rdy[i+1]));
    end

    push  = in_vld & in_rdy;
    pop   = vld[DEPTH-1] & out_rdy;
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [W-1:0] stage_in;
    if (g == 0) begin : g_first
      assign stage_in = in_dat;
    end else begin : g_rest
      assign stage_in = dat[g-1];
    end

    pipe_reg_stage #(
      .W    (W),
      .INIT (INIT)
    ) u_stage (
      .clk      (clk),
      .arst_n   (arst_n),
      .load     (xfer[g]),
      .vld_next (vld_d[g]),
      .dat_in   (stage_in),
      .vld      (vld[g]),
      .dat      (dat[g])
    );
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_vld = vld[DEPTH-1];
  assign out_dat = dat[DEPTH-1];
  assign cnt     = cnt_q;

  a_ctrl_known: assert property (@(posedge clk) disable iff (!arst_n)
    !$isunknown({in_vld, out_rdy, flush}));

  // Upstream may withdraw a stalled word, but must not change it while still offering it.
  a_dat_stable: assert property (@(posedge clk) disable iff (!arst_n)
    (in_vld && !in_rdy) |=> (!in_vld || $stable(in_dat)));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!arst_n)
    cnt_q <= CW'(DEPTH));

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - self-checking bench for pipe_reg: vector table, corner sequences, random scoreboard
module tb_pipe_reg;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       in_vld, in_rdy, out_vld, out_rdy, flush;
  logic [7:0] in_dat, out_dat;
  logic [1:0] cnt;

  logic       in_vld4, in_rdy4, out_vld4, out_rdy4, flush4;
  logic [7:0] in_dat4, out_dat4;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_reg #(.W(8), .DEPTH(D), .INIT(8'h5A)) u_dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .in_vld  (in_vld),
    .in_dat  (in_dat),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_dat (out_dat),
    .out_rdy (out_rdy),
    .flush   (flush),
    .cnt     (cnt)
  );

  pipe_reg #(.W(8), .DEPTH(4), .INIT(8'h00)) u_dut4 (
    .clk     (clk),
    .arst_n  (arst_n),
    .in_vld  (in_vld4),
    .in_dat  (in_dat4),
    .in_rdy  (in_rdy4),
    .out_vld (out_vld4),
    .out_dat (out_dat4),
    .out_rdy (out_rdy4),
    .flush   (flush4),
    .cnt     (cnt4)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       e_irdy;
    logic       e_ovld;
    logic [7:0] e_odat;
    logic       chk_dat;
    logic [1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] dat;
    int         ready_at;
  } word_t;

  vec_t  vt[$];
  word_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                     input logic irdy, input logic ovld, input logic [7:0] odat,
                     input logic cd, input logic [1:0] c);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_irdy = irdy; v.e_ovld = ovld; v.e_odat = odat; v.chk_dat = cd; v.e_cnt = c;
    vt.push_back(v);
  endtask

  initial begin
    int         n;
    bit         pend;
    logic       e_irdy, e_ovld;
    word_t      w;

    in_vld = 0; in_dat = 0; out_rdy = 1; flush = 0;
    in_vld4 = 0; in_dat4 = 0; out_rdy4 = 0; flush4 = 0;

    // Reset state is visible before any clock edge.
    #2 arst_n = 0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 8'h5A);
    chk("rst_cnt", cnt, 0);
    chk("rst_in_rdy", in_rdy, 1);
    @(negedge clk);
    arst_n = 1;

    // Cycle-by-cycle table: back-to-back fill/drain, full stall, flush, refill.
    add(1,'h11,1,0, 1,0,'h5A,1,0);
    add(1,'h22,1,0, 1,0,'h5A,1,1);
    add(1,'h33,1,0, 1,0,'h5A,1,2);
    add(0,'h00,1,0, 1,1,'h11,1,3);
    add(0,'h00,1,0, 1,1,'h22,1,2);
    add(0,'h00,1,0, 1,1,'h33,1,1);
    add(0,'h00,1,0, 1,0,'h33,1,0);
    add(1,'h41,0,0, 1,0,'h33,1,0);
    add(1,'h42,0,0, 1,0,'h33,1,1);
    add(1,'h43,0,0, 1,0,'h33,1,2);
    add(1,'h44,0,0, 0,1,'h41,1,3);
    add(1,'h44,0,0, 0,1,'h41,1,3);
    add(1,'h44,1,0, 1,1,'h41,1,3);
    add(0,'h00,1,0, 1,1,'h42,1,3);
    add(0,'h00,1,0, 1,1,'h43,1,2);
    add(0,'h00,1,0, 1,1,'h44,1,1);
    add(0,'h00,1,0, 1,0,'h44,1,0);
    add(1,'h51,0,0, 1,0,'h44,1,0);
    add(1,'h52,0,0, 1,0,'h44,1,1);
    add(1,'h53,0,1, 0,0,'h44,1,2);
    add(1,'h53,0,0, 1,0,'h00,0,0);
    add(0,'h00,1,0, 1,0,'h00,0,1);
    add(0,'h00,1,0, 1,0,'h00,0,1);
    add(0,'h00,1,0, 1,1,'h53,1,1);
    add(0,'h00,1,0, 1,0,'h53,1,0);

    foreach (vt[k]) begin
      @(negedge clk);
      in_vld = vt[k].iv; in_dat = vt[k].id; out_rdy = vt[k].ordy; flush = vt[k].fl;
      #1;
      chk($sformatf("vec%0d_in_rdy", k), in_rdy, vt[k].e_irdy);
      chk($sformatf("vec%0d_out_vld", k), out_vld, vt[k].e_ovld);
      if (vt[k].chk_dat) chk($sformatf("vec%0d_out_dat", k), out_dat, vt[k].e_odat);
      chk($sformatf("vec%0d_cnt", k), cnt, vt[k].e_cnt);
    end

    // Asynchronous reset mid-stream with two words in flight.
    @(negedge clk); in_vld = 1; in_dat = 8'h61; out_rdy = 0;
    @(negedge clk); in_dat = 8'h62;
    @(negedge clk); in_vld = 0;
    #1;
    chk("pre_rst_cnt", cnt, 2);
    #1 arst_n = 0;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_out_dat", out_dat, 8'h5A);
    chk("arst_cnt", cnt, 0);
    chk("arst_in_rdy", in_rdy, 1);
    @(negedge clk);
    arst_n = 1; in_vld = 1; in_dat = 8'h71; out_rdy = 1;
    n = 0;
    do begin
      @(negedge clk); in_vld = 0; #1; n++;
    end while (!out_vld && n < 8);
    chk("post_rst_vld", out_vld, 1);
    chk("post_rst_dat", out_dat, 8'h71);
    chk("post_rst_latency", n, 3);

    // DEPTH=4: lone word collapses through bubbles to the output despite out_rdy=0.
    @(negedge clk); in_vld4 = 1; in_dat4 = 8'hA5; out_rdy4 = 0;
    #1;
    chk("d4_in_rdy", in_rdy4, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); in_vld4 = 0; #1;
      chk($sformatf("d4_out_vld_c%0d", k), out_vld4, (k == 4) ? 1 : 0);
    end
    chk("d4_out_dat", out_dat4, 8'hA5);
    chk("d4_cnt", cnt4, 1);

    // Random traffic against a timestamped in-order scoreboard.
    @(negedge clk); arst_n = 0; in_vld = 0; flush = 0; out_rdy = 0;
    @(negedge clk); arst_n = 1;
    sb.delete();
    pend = 0;
    for (int t = 0; t < 10000; t++) begin
      @(negedge clk);
      if (!pend) begin
        in_vld = ($urandom_range(0, 9) < 6);
        in_dat = 8'($urandom);
      end
      out_rdy = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 39) == 0);
      #1;
      e_irdy = !flush && (sb.size() < D || out_rdy);
      e_ovld = (sb.size() > 0) && (t >= sb[0].ready_at);
      chk($sformatf("rnd%0d_in_rdy", t), in_rdy, e_irdy);
      chk($sformatf("rnd%0d_out_vld", t), out_vld, e_ovld);
      chk($sformatf("rnd%0d_cnt", t), cnt, sb.size());
      if (e_ovld) chk($sformatf("rnd%0d_out_dat", t), out_dat, sb[0].dat);

      if (e_ovld && out_rdy) begin
        void'(sb.pop_front());
        if (sb.size() > 0) begin
          w = sb.pop_front();
          if (w.ready_at < t + 1) w.ready_at = t + 1;
          sb.push_front(w);
        end
      end
      if (flush) begin
        sb.delete();
      end else if (in_vld && e_irdy) begin
        w.dat = in_dat;
        w.ready_at = t + D;
        sb.push_back(w);
      end
      pend = in_vld && !e_irdy;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter W, default 1, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 Parameter INIT, default 'b0, W-bit reset value of every stage data register.
REQ-004 clk  input  1  clock, all state updates on posedge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_vld  input  1  upstream word valid.
REQ-007 in_dat  input  W  upstream word.
REQ-008 in_rdy  output  1  block accepts upstream word this cycle.
REQ-009 out_vld  output  1  final stage holds a valid word.
REQ-010 out_dat  output  W  final stage data.
REQ-011 out_rdy  input  1  downstream accepts final-stage word this cycle.
REQ-012 flush  input  1  synchronous discard of all in-flight words.
REQ-013 cnt  output  CW  count of valid stages, CW = $clog2(DEPTH+1).

Function
REQ-014 Each stage i (0 = input side, DEPTH-1 = output side) holds vld[i] and dat[i].
REQ-015 Stage ready: rdy[i] = ~vld[i] | rdy[i+1]; rdy[DEPTH] = out_rdy.
REQ-016 Bubble collapse: an empty stage accepts from upstream regardless of out_rdy.
REQ-017 Transfer into stage i when vld[i-1] & rdy[i] (stage 0: in_vld & in_rdy).
REQ-018 dat[i] loads only on a transfer into stage i; otherwise it holds, including after the word leaves.
REQ-019 vld[i] next = transfer-in to i, else vld[i] & ~rdy[i+1].
REQ-020 in_rdy = rdy[0] & ~flush; out_vld = vld[DEPTH-1]; out_dat = dat[DEPTH-1].
REQ-021 Minimum latency: word accepted at cycle T appears on out_vld/out_dat at cycle T+DEPTH when all downstream stages are empty or moving.
REQ-022 Full (all vld set, out_rdy=0): in_rdy=0, no stage moves, all data held.
REQ-023 Full with out_rdy=1: all stages shift simultaneously and in_rdy=1 (throughput 1 word/cycle).
REQ-024 Ordering: words leave in acceptance order; no loss, no duplication.
REQ-025 flush=1: next cycle all vld=0, cnt=0; a handshake on out in the flush cycle still completes; no input accepted in the flush cycle.
REQ-026 cnt next = cnt + (in_vld & in_rdy) - (out_vld & out_rdy), or 0 on flush; never exceeds DEPTH.
REQ-027 Assertion: in_vld, out_rdy, flush never X/Z outside reset.
REQ-028 Assertion: in_dat stable while in_vld & ~in_rdy (upstream protocol).

Reset
REQ-029 arst_n low: all vld=0, all dat=INIT, cnt=0, out_vld=0, out_dat=INIT, in_rdy=1 immediately (async).
REQ-030 Reset mid-operation discards all in-flight words; first accepted word after release is the first word out.

Structure
REQ-031 CW derivation and any stage-state typedef belong in the shared common package, not local to the module.
REQ-032 One sub-module, pipe_reg_stage (single vld/dat stage with load-enable, INIT reset), instantiated DEPTH times in a generate loop.
REQ-033 The ready chain is combinational through all stages; no skid buffer.

Verification
REQ-034 W=8, DEPTH=3, out_rdy=1, push 0x11,0x22,0x33 back-to-back -> out 0x11 at cycle 3, then 0x22, 0x33 consecutively; cnt peaks at 3.
REQ-035 DEPTH=3, out_rdy=0, push 4 words -> in_rdy drops after 3rd, cnt=3, 4th held by upstream; raise out_rdy -> 4 words out in order, 1/cycle.
REQ-036 DEPTH=4, one word 0xA5 into empty pipe, out_rdy=0 -> word reaches stage 3 at cycle 4 (bubbles collapse), cnt=1.
REQ-037 Pipe holding 2 words, assert flush with in_vld=1 -> in_rdy=0 that cycle; next cycle out_vld=0, cnt=0; next push emerges normally.
REQ-038 INIT=8'h5A, drop arst_n mid-stream with cnt=2 -> out_vld=0, out_dat=0x5A, cnt=0 without clock edge.
REQ-039 Random in_vld/out_rdy, 10k cycles, scoreboard -> zero mismatches, cnt matches scoreboard occupancy every cycle.
